mem_port_arbiter: RTL and testbench

//  Shares one memory port between the core's instruction-fetch and data requesters.

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the instruction-fetch and data requesters onto one shared memory port
// and routes each memory response back to the requester that issued it.
package mem_port_arbiter_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic        do_read;
    logic        do_write;
  } memory_io_req;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
  } memory_io_rsp;
endpackage

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LATENCY      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  memory_io_req inst_req,
  output memory_io_rsp inst_rsp,
  output logic         inst_stall,
  input  memory_io_req data_req,
  output memory_io_rsp data_rsp,
  output logic         data_stall,
  output memory_io_req mem_req,
  input  memory_io_rsp mem_rsp,
  output logic [15:0]  starve_events,
  output logic         proto_err
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  localparam logic [0:0] DATA_PRI = 1'b0;
  localparam logic [0:0] INST_PRI = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [15:0]      events_q, events_d;
  logic             proto_err_q, proto_err_d;

  logic grant_inst, grant_data, grant_any, forced_grant;

  // Owner pipeline: flush marks slots whose response belongs to a pre-reset request.
  logic [LATENCY-1:0] own_vld_q, own_vld_d;
  logic [LATENCY-1:0] own_id_q, own_id_d;
  logic [LATENCY-1:0] own_flush_q, own_flush_d;
  logic tail_vld, tail_id, tail_flush;

  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (!reset) begin
      if (inst_req.valid && data_req.valid) begin
        grant_inst = (state_q == INST_PRI);
        grant_data = (state_q != INST_PRI);
      end else begin
        grant_inst = inst_req.valid;
        grant_data = data_req.valid;
      end
    end
  end

  assign grant_any    = grant_inst | grant_data;
  assign forced_grant = (state_q == INST_PRI) & grant_inst & data_req.valid;

  assign inst_stall = inst_req.valid & ~grant_inst;
  assign data_stall = data_req.valid & ~grant_data;

  always_comb begin
    mem_req = '0;
    if (grant_inst) begin
      mem_req = inst_req;
    end else if (grant_data) begin
      mem_req = data_req;
    end
  end

  always_comb begin
    starve_cnt_d = '0;
    if (inst_req.valid && !grant_inst) begin
      starve_cnt_d = (starve_cnt_q == CNT_MAX) ? starve_cnt_q : starve_cnt_q + 1'b1;
    end
  end

  // INST_PRI lines up with the cycle in which starve_cnt sits at its limit.
  always_comb begin
    state_d = DATA_PRI;
    case (state_q)
      DATA_PRI: state_d = (starve_cnt_d == CNT_MAX) ? INST_PRI : DATA_PRI;
      INST_PRI: state_d = DATA_PRI;
      default:  state_d = DATA_PRI;
    endcase
  end

  assign events_d = (forced_grant && events_q != 16'hFFFF) ? events_q + 16'd1 : events_q;

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_owner
      if (gi == 0) begin : g_head
        assign own_vld_d[gi]   = grant_any;
        assign own_id_d[gi]    = grant_data;
        assign own_flush_d[gi] = 1'b0;
      end else begin : g_body
        assign own_vld_d[gi]   = own_vld_q[gi-1];
        assign own_id_d[gi]    = own_id_q[gi-1];
        assign own_flush_d[gi] = own_flush_q[gi-1];
      end
    end
  endgenerate

  assign tail_vld   = own_vld_q[LATENCY-1];
  assign tail_id    = own_id_q[LATENCY-1];
  assign tail_flush = own_flush_q[LATENCY-1];

  always_comb begin
    inst_rsp    = '0;
    data_rsp    = '0;
    proto_err_d = proto_err_q;
    if (!reset && mem_rsp.valid) begin
      if (tail_vld) begin
        if (tail_id) begin
          data_rsp = mem_rsp;
        end else begin
          inst_rsp = mem_rsp;
        end
      end else if (!tail_flush) begin
        proto_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= DATA_PRI;
      starve_cnt_q <= '0;
      events_q     <= '0;
      proto_err_q  <= 1'b0;
      own_vld_q    <= '0;
      own_id_q     <= '0;
      own_flush_q  <= '1;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      events_q     <= events_d;
      proto_err_q  <= proto_err_d;
      own_vld_q    <= own_vld_d;
      own_id_q     <= own_id_d;
      own_flush_q  <= own_flush_d;
    end
  end

  assign starve_events = events_q;
  assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios pinned by literals, then random
// traffic checked every cycle against a queue-based behavioural model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int LAT = 1;
  localparam int LIM = 4;

  logic         clk = 1'b0;
  logic         reset;
  memory_io_req inst_req, data_req, mem_req;
  memory_io_rsp inst_rsp, data_rsp, mem_rsp;
  logic         inst_stall, data_stall;
  logic [15:0]  starve_events;
  logic         proto_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LATENCY(LAT), .STARVE_LIMIT(LIM)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_rsp     (inst_rsp),
    .inst_stall   (inst_stall),
    .data_req     (data_req),
    .data_rsp     (data_rsp),
    .data_stall   (data_stall),
    .mem_req      (mem_req),
    .mem_rsp      (mem_rsp),
    .starve_events(starve_events),
    .proto_err    (proto_err)
  );

  // Model state: who owns each in-flight slot, tagged with the reset epoch it was issued in.
  typedef struct {
    bit vld;
    bit id;
    int epoch;
  } own_t;

  own_t         own_q[$];
  memory_io_rsp mem_q[$];
  int           m_streak = 0;
  int           m_events = 0;
  bit           m_proto  = 1'b0;
  int           m_epoch  = 0;
  bit           last_is  = 1'b0;
  bit           last_ds  = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic memory_io_rsp mem_answer(input memory_io_req r);
    memory_io_rsp a;
    a.valid = 1'b1;
    a.addr  = r.addr;
    a.data  = r.do_write ? r.data : (r.addr ^ 32'h5A5A_C3C3);
    return a;
  endfunction

  // Compare process: check outputs against the model, then advance model and memory.
  always @(negedge clk) begin
    own_t         tail, nxt;
    bit           g_i, g_d, deliver, perr;
    memory_io_req exp_mem;
    memory_io_rsp exp_i, exp_d;

    tail = own_q[0];
    g_i  = 1'b0;
    g_d  = 1'b0;
    if (!reset) begin
      if (inst_req.valid && data_req.valid) begin
        if (m_streak >= LIM) g_i = 1'b1;
        else g_d = 1'b1;
      end else begin
        g_i = inst_req.valid;
        g_d = data_req.valid;
      end
    end
    exp_mem = g_i ? inst_req : (g_d ? data_req : '0);

    deliver = !reset && mem_rsp.valid && tail.epoch == m_epoch && tail.vld;
    perr    = !reset && mem_rsp.valid && tail.epoch == m_epoch && !tail.vld;
    exp_i   = '0;
    exp_d   = '0;
    if (deliver) begin
      if (tail.id) exp_d = mem_rsp;
      else exp_i = mem_rsp;
      $display("cyc=%0d rsp->%s addr=%08h data=%08h", cyc, tail.id ? "data" : "inst",
               mem_rsp.addr, mem_rsp.data);
    end

    chk("inst_stall", 128'(inst_stall), 128'(inst_req.valid & ~g_i));
    chk("data_stall", 128'(data_stall), 128'(data_req.valid & ~g_d));
    chk("mem_req", 128'(mem_req), 128'(exp_mem));
    chk("inst_rsp", 128'(inst_rsp), 128'(exp_i));
    chk("data_rsp", 128'(data_rsp), 128'(exp_d));
    chk("starve_events", 128'(starve_events), 128'(m_events));
    chk("proto_err", 128'(proto_err), 128'(m_proto));

    mem_q.push_back(mem_req.valid ? mem_answer(mem_req) : '0);
    void'(own_q.pop_front());
    nxt.vld   = g_i | g_d;
    nxt.id    = g_d;
    nxt.epoch = m_epoch;
    own_q.push_back(nxt);

    if (reset) begin
      m_streak = 0;
      m_events = 0;
      m_proto  = 1'b0;
      m_epoch++;
    end else begin
      if (inst_req.valid && !g_i) m_streak++;
      else m_streak = 0;
      if (g_i && data_req.valid && m_events < 65535) m_events++;
      if (perr) m_proto = 1'b1;
    end
    last_is = inst_req.valid & ~g_i;
    last_ds = data_req.valid & ~g_d;
  end

  task automatic step(input bit r, input memory_io_req ir, input memory_io_req dr, input bit inj);
    @(posedge clk);
    #1;
    cyc++;
    mem_rsp = mem_q.pop_front();
    if (inj && !mem_rsp.valid) begin
      mem_rsp.valid = 1'b1;
      mem_rsp.addr  = $urandom;
      mem_rsp.data  = $urandom;
    end
    reset    = r;
    inst_req = ir;
    data_req = dr;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  function automatic memory_io_req rd(input logic [31:0] a);
    memory_io_req r;
    r          = '0;
    r.valid    = 1'b1;
    r.addr     = a;
    r.do_read  = 1'b1;
    return r;
  endfunction

  function automatic memory_io_req rnd_req(input bit v);
    memory_io_req r;
    bit w;
    w          = 1'($urandom_range(0, 1));
    r.valid    = v;
    r.addr     = $urandom;
    r.data     = $urandom;
    r.do_read  = ~w;
    r.do_write = w;
    return r;
  endfunction

  initial begin
    memory_io_req idle, ir, dr;
    idle     = '0;
    reset    = 1'b1;
    inst_req = '0;
    data_req = '0;
    mem_rsp  = '0;
    for (int i = 0; i < LAT; i++) begin
      own_t e;
      e.vld   = 1'b0;
      e.id    = 1'b0;
      e.epoch = -1;
      own_q.push_back(e);
      mem_q.push_back('0);
    end

    repeat (3) step(1'b1, idle, idle, 1'b0);
    settle();
    chk("reset_events", 128'(starve_events), 128'(0));
    chk("reset_proto", 128'(proto_err), 128'(0));

    // T1: fetch-only stream
    step(1'b0, rd(32'h0001_0000), idle, 1'b0);
    settle();
    chk("t1_stall", 128'(inst_stall), 128'(0));
    chk("t1_mem_addr", 128'(mem_req.addr), 128'(32'h0001_0000));
    step(1'b0, rd(32'h0001_0000), idle, 1'b0);
    settle();
    chk("t1_rsp_valid", 128'(inst_rsp.valid), 128'(1));
    chk("t1_rsp_addr", 128'(inst_rsp.addr), 128'(32'h0001_0000));
    chk("t1_drsp_valid", 128'(data_rsp.valid), 128'(0));
    step(1'b0, rd(32'h0001_0000), idle, 1'b0);
    step(1'b0, idle, idle, 1'b0);
    settle();
    chk("t1_last_rsp", 128'(inst_rsp.valid), 128'(1));

    // T2: collision, data first then the held fetch
    step(1'b0, rd(32'h0000_2000), rd(32'h0000_3000), 1'b0);
    settle();
    chk("t2_istall", 128'(inst_stall), 128'(1));
    chk("t2_dstall", 128'(data_stall), 128'(0));
    chk("t2_mem_addr", 128'(mem_req.addr), 128'(32'h0000_3000));
    step(1'b0, rd(32'h0000_2000), idle, 1'b0);
    settle();
    chk("t2_drsp_addr", 128'(data_rsp.addr), 128'(32'h0000_3000));
    chk("t2_mem_addr2", 128'(mem_req.addr), 128'(32'h0000_2000));
    step(1'b0, idle, idle, 1'b0);
    settle();
    chk("t2_irsp_addr", 128'(inst_rsp.addr), 128'(32'h0000_2000));

    // T3: continuous contention, fetch wins every fifth cycle
    for (int k = 0; k < 10; k++) begin
      step(1'b0, rd(32'h0000_7000), rd(32'h0000_8000 + 32'(k * 4)), 1'b0);
      settle();
      chk("t3_istall", 128'(inst_stall), 128'((k % 5) != 4));
      chk("t3_events", 128'(starve_events), 128'((k >= 5) ? 1 : 0));
    end
    step(1'b0, idle, idle, 1'b0);
    settle();
    chk("t3_events_end", 128'(starve_events), 128'(2));

    // T4: alternating owners at full rate
    step(1'b0, idle, rd(32'h0000_4000), 1'b0);
    step(1'b0, rd(32'h0000_5000), idle, 1'b0);
    settle();
    chk("t4_d0", 128'(data_rsp.addr), 128'(32'h0000_4000));
    step(1'b0, idle, rd(32'h0000_4004), 1'b0);
    settle();
    chk("t4_i0", 128'(inst_rsp.addr), 128'(32'h0000_5000));
    step(1'b0, rd(32'h0000_5004), idle, 1'b0);
    settle();
    chk("t4_d1", 128'(data_rsp.addr), 128'(32'h0000_4004));
    step(1'b0, idle, idle, 1'b0);
    settle();
    chk("t4_i1", 128'(inst_rsp.addr), 128'(32'h0000_5004));

    // T5: orphan response
    step(1'b0, idle, idle, 1'b1);
    settle();
    chk("t5_irsp", 128'(inst_rsp.valid), 128'(0));
    chk("t5_drsp", 128'(data_rsp.valid), 128'(0));
    step(1'b0, idle, idle, 1'b0);
    step(1'b0, idle, idle, 1'b0);
    settle();
    chk("t5_sticky", 128'(proto_err), 128'(1));

    // T6: reset with a data read in flight and fetch partly starved
    for (int k = 0; k < 3; k++) step(1'b0, rd(32'h0000_9000), rd(32'h0000_6000 + 32'(k * 4)), 1'b0);
    step(1'b1, rd(32'h0000_9000), rd(32'h0000_6010), 1'b0);
    settle();
    chk("t6_rst_drsp", 128'(data_rsp.valid), 128'(0));
    chk("t6_rst_mem", 128'(mem_req.valid), 128'(0));
    chk("t6_rst_dstall", 128'(data_stall), 128'(1));
    for (int k = 0; k < 5; k++) begin
      step(1'b0, rd(32'h0000_9000), rd(32'h0000_6020 + 32'(k * 4)), 1'b0);
      settle();
      if (k == 0) begin
        chk("t6_post_drsp", 128'(data_rsp.valid), 128'(0));
        chk("t6_post_events", 128'(starve_events), 128'(0));
        chk("t6_post_proto", 128'(proto_err), 128'(0));
      end
      chk("t6_istall", 128'(inst_stall), 128'(k < 4));
    end

    // Random traffic, requesters hold stalled requests
    ir = '0;
    dr = '0;
    for (int n = 0; n < 1500; n++) begin
      int pi, pd;
      case (n / 300)
        0:       begin pi = 90; pd = 90; end
        1:       begin pi = 30; pd = 80; end
        2:       begin pi = 80; pd = 30; end
        3:       begin pi = 100; pd = 100; end
        default: begin pi = 50; pd = 50; end
      endcase
      if (!last_is) ir = rnd_req($urandom_range(0, 99) < pi);
      if (!last_ds) dr = rnd_req($urandom_range(0, 99) < pd);
      step($urandom_range(0, 199) == 0, ir, dr, $urandom_range(0, 59) == 0);
    end
    step(1'b0, idle, idle, 1'b0);
    step(1'b0, idle, idle, 1'b0);
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
